led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 172 +++++++++++++++++
 tb/tb_led_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl
// Brief    : Four-channel 100-step PWM LED driver, commanded by decoded SPI
//            frames, with an optional SPI readback path (LED_CTRL_READBACK_EN).
// Revision : 1.0 - initial release
// ============================================================================

module led_ctrl #(
  parameter int PWM_DIV = 1250
) (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_cmd,
  input  logic [7:0]  i_addr,
  input  logic [7:0]  i_payload,
  input  logic        i_cs,
  output logic [3:0]  o_led,
  output logic [23:0] o_slv_frame,
  output logic        o_slv_tx_enb,
  output logic [7:0]  o_err_cnt
);

  localparam int          c_presc_w  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [7:0]  c_cmd_wr   = 8'h01;
  localparam logic [7:0]  c_cmd_rd   = 8'h02;
  localparam logic [6:0]  c_step_max = 7'd99;
  localparam logic [6:0]  c_duty_max = 7'd100;

  logic [c_presc_w-1:0] r_presc;
  logic [6:0]           r_step;
  logic [6:0]           r_shadow [4];
  logic [6:0]           r_active [4];
  logic [7:0]           r_err_cnt;

  logic       w_tick;
  logic       w_wrap;
  logic       w_addr_ok;
  logic [1:0] w_addr;
  logic       w_wr;
  logic       w_rd;
  logic       w_bad;
  logic [6:0] w_duty_in;

  assign w_tick    = (r_presc == c_presc_w'(PWM_DIV - 1));
  assign w_wrap    = w_tick && (r_step == c_step_max);
  assign w_addr_ok = (i_addr < 8'd4);
  assign w_addr    = i_addr[1:0];
  assign w_wr      = i_rx_dv && (i_cmd == c_cmd_wr) && w_addr_ok;
  assign w_bad     = i_rx_dv && !w_wr && !w_rd;
  assign w_duty_in = (i_payload > 8'd100) ? c_duty_max : i_payload[6:0];

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_presc <= '0;
      r_step  <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_step  <= (r_step == c_step_max) ? 7'd0 : r_step + 7'd1;
    end else begin
      r_presc <= r_presc + c_presc_w'(1);
    end
  end

  // Active copy takes the pre-edge shadow, so a WRITE landing on the wrap
  // edge only shows up one full period later.
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wrap) begin
        for (int i = 0; i < 4; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_wr) begin
        r_shadow[w_addr] <= w_duty_in;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_err_cnt <= '0;
    end else if (w_bad && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;

  for (genvar g = 0; g < 4; g++) begin : g_led
    assign o_led[g] = (r_step < r_active[g]);
  end

`ifdef LED_CTRL_READBACK_EN
  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_armed   = 2'd1;
  localparam logic [1:0] c_st_sending = 2'd2;

  logic        r_cs_meta;
  logic        r_cs_sync;
  logic [1:0]  r_state;
  logic        r_pend;
  logic [1:0]  r_pend_addr;
  logic [23:0] r_frame;

  assign w_rd = i_rx_dv && (i_cmd == c_cmd_rd) && w_addr_ok;

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_state     <= c_st_idle;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_frame     <= '0;
    end else begin
      r_cs_meta <= i_cs;
      r_cs_sync <= r_cs_meta;
      case (r_state)
        c_st_idle: begin
          // A fresh READ supersedes one deferred during the last transfer.
          if (w_rd) begin
            r_frame <= {c_cmd_rd, 6'd0, w_addr, 1'b0, r_active[w_addr]};
            r_pend  <= 1'b0;
            r_state <= c_st_armed;
          end else if (r_pend) begin
            r_frame <= {c_cmd_rd, 6'd0, r_pend_addr, 1'b0, r_active[r_pend_addr]};
            r_pend  <= 1'b0;
            r_state <= c_st_armed;
          end
        end
        c_st_armed: begin
          if (w_rd) begin
            r_frame <= {c_cmd_rd, 6'd0, w_addr, 1'b0, r_active[w_addr]};
          end else if (!r_cs_sync) begin
            r_state <= c_st_sending;
          end
        end
        c_st_sending: begin
          if (w_rd) begin
            r_pend      <= 1'b1;
            r_pend_addr <= w_addr;
          end
          if (r_cs_sync) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign o_slv_frame  = r_frame;
  assign o_slv_tx_enb = (r_state != c_st_idle);
`else
  logic w_cs_unused;

  assign w_rd         = 1'b0;
  assign w_cs_unused  = i_cs;
  assign o_slv_frame  = '0;
  assign o_slv_tx_enb = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_ctrl
// Brief    : Randomised and directed bench for led_ctrl against a period-level
//            reference model (time index -> PWM step, duties copied on wraps).
// Revision : 1.0 - initial release
// ============================================================================

module tb_led_ctrl;

  localparam int PWM_DIV = 4;
  localparam int PERIOD  = PWM_DIV * 100;
`ifdef LED_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        rstn;
  logic        i_rx_dv;
  logic [7:0]  i_cmd;
  logic [7:0]  i_addr;
  logic [7:0]  i_payload;
  logic        i_cs;
  logic [3:0]  o_led;
  logic [23:0] o_slv_frame;
  logic        o_slv_tx_enb;
  logic [7:0]  o_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_n counts enabled clock edges since reset.
  int          m_shadow [4];
  int          m_active [4];
  int          m_err;
  int          m_n;
  logic [23:0] m_frame;
  bit          m_rd_seen;
  bit          m_chk_fr;

  led_ctrl #(.PWM_DIV(PWM_DIV)) u_dut (
    .sysclk      (sysclk),
    .rstn        (rstn),
    .i_rx_dv     (i_rx_dv),
    .i_cmd       (i_cmd),
    .i_addr      (i_addr),
    .i_payload   (i_payload),
    .i_cs        (i_cs),
    .o_led       (o_led),
    .o_slv_frame (o_slv_frame),
    .o_slv_tx_enb(o_slv_tx_enb),
    .o_err_cnt   (o_err_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_led();
    int step;
    logic [3:0] r;
    step = (m_n / PWM_DIV) % 100;
    for (int i = 0; i < 4; i++) r[i] = (step < m_active[i]);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_err     = 0;
    m_n       = 0;
    m_frame   = '0;
    m_rd_seen = 1'b0;
  endfunction

  function automatic void model_edge(bit dv, logic [7:0] cmd, logic [7:0] addr, logic [7:0] pay);
    bit is_rd;
    is_rd = dv && RB && (cmd == 8'h02) && (addr < 8'd4);
    if (is_rd) begin
      m_frame   = {8'h02, addr, 8'(m_active[addr[1:0]])};
      m_rd_seen = 1'b1;
    end
    if ((m_n % PERIOD) == PERIOD - 1) begin
      for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
    end
    if (dv) begin
      if (cmd == 8'h01 && addr < 8'd4) m_shadow[addr[1:0]] = (pay > 8'd100) ? 100 : int'(pay);
      else if (!is_rd) m_err = (m_err < 255) ? m_err + 1 : 255;
    end
    m_n++;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit dv, input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] pay);
    i_rx_dv   = dv;
    i_cmd     = cmd;
    i_addr    = addr;
    i_payload = pay;
    @(posedge sysclk);
    model_edge(dv, cmd, addr, pay);
    #1;
    check_val("led", 32'(o_led), 32'(exp_led()));
    check_val("err_cnt", 32'(o_err_cnt), 32'(m_err));
    if (m_chk_fr) begin
      check_val("tx_enb", 32'(o_slv_tx_enb), 32'(m_rd_seen));
      check_val("frame", 32'(o_slv_frame), 32'(m_frame));
    end
    @(negedge sysclk);
    i_rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    i_rx_dv = 1'b0;
    @(posedge sysclk);
    model_reset();
    #1;
    check_val("rst_led", 32'(o_led), 32'h0);
    check_val("rst_err", 32'(o_err_cnt), 32'h0);
    check_val("rst_enb", 32'(o_slv_tx_enb), 32'h0);
    check_val("rst_frame", 32'(o_slv_frame), 32'h0);
    @(negedge sysclk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_on;
    int cnt_other;

    rstn      = 1'b0;
    i_rx_dv   = 1'b0;
    i_cmd     = '0;
    i_addr    = '0;
    i_payload = '0;
    i_cs      = 1'b1;
    m_chk_fr  = 1'b0;
    model_reset();
    @(negedge sysclk);
    do_reset();

    // 50 % duty on LED2: exactly half of one full period after the wrap.
    cyc(1'b1, 8'h01, 8'd2, 8'd50);
    while (m_n < PERIOD) idle(1);
    cnt_on    = 0;
    cnt_other = 0;
    for (int k = 0; k < PERIOD; k++) begin
      idle(1);
      cnt_on    += int'(o_led[2]);
      cnt_other += int'((o_led & 4'b1011) != 4'b0000);
    end
    check_val("led2_half_on", 32'(cnt_on), 32'd200);
    check_val("led_others_off", 32'(cnt_other), 32'd0);

    // Over-range payload clamps to 100 -> LED0 permanently on, no error.
    cyc(1'b1, 8'h01, 8'd0, 8'd200);
    while (m_n < 3 * PERIOD) idle(1);
    cnt_on = 0;
    for (int k = 0; k < PERIOD; k++) begin
      idle(1);
      cnt_on += int'(o_led[0]);
    end
    check_val("led0_clamp_on", 32'(cnt_on), 32'd400);
    check_val("clamp_no_err", 32'(o_err_cnt), 32'd0);

    // WRITE on the wrap edge waits for the following wrap.
    while ((m_n % PERIOD) != PERIOD - 1) idle(1);
    cyc(1'b1, 8'h01, 8'd3, 8'd70);
    check_val("wr_on_wrap_deferred", 32'(o_led[3]), 32'd0);
    idle(1);
    while ((m_n % PERIOD) != 0) idle(1);
    check_val("wr_on_wrap_applied", 32'(o_led[3]), 32'd1);

    // Error counter: bad cmd, bad addr, then saturation.
    do_reset();
    cyc(1'b1, 8'h07, 8'd0, 8'd10);
    check_val("err_bad_cmd", 32'(o_err_cnt), 32'd1);
    cyc(1'b1, 8'h01, 8'd9, 8'd10);
    check_val("err_bad_addr", 32'(o_err_cnt), 32'd2);
    for (int k = 0; k < 300; k++) cyc(1'b1, 8'h00, 8'(k), 8'(k));
    check_val("err_saturate", 32'(o_err_cnt), 32'd255);
    idle(PERIOD);
    check_val("err_duty_untouched", 32'(o_led), 32'd0);

`ifdef LED_CTRL_READBACK_EN
    do_reset();
    cyc(1'b1, 8'h01, 8'd1, 8'd30);
    cyc(1'b1, 8'h01, 8'd2, 8'd80);
    while (m_n < PERIOD + 1) idle(1);
    cyc(1'b1, 8'h02, 8'd1, 8'd0);
    check_val("rd_frame", 32'(o_slv_frame), 32'h02011E);
    check_val("rd_enb", 32'(o_slv_tx_enb), 32'd1);
    i_cs = 1'b0;
    idle(4);
    check_val("sending_enb", 32'(o_slv_tx_enb), 32'd1);
    check_val("sending_frame_held", 32'(o_slv_frame), 32'h02011E);
    i_cs = 1'b1;
    idle(4);
    check_val("cs_release_enb", 32'(o_slv_tx_enb), 32'd0);

    // READ during SENDING is deferred until CS releases.
    cyc(1'b1, 8'h02, 8'd1, 8'd0);
    i_cs = 1'b0;
    idle(4);
    cyc(1'b1, 8'h02, 8'd2, 8'd0);
    check_val("defer_frame_held", 32'(o_slv_frame), 32'h02011E);
    check_val("defer_enb", 32'(o_slv_tx_enb), 32'd1);
    i_cs = 1'b1;
    idle(1);
    check_val("defer_frame_still", 32'(o_slv_frame), 32'h02011E);
    idle(5);
    check_val("defer_rearmed", 32'(o_slv_tx_enb), 32'd1);
    check_val("defer_frame_new", 32'(o_slv_frame), 32'h020250);

    // Reset mid-transfer, with a READ pending, leaves nothing behind.
    cyc(1'b1, 8'h02, 8'd3, 8'd0);
    check_val("armed_reload", 32'(o_slv_frame), 32'h020300);
    i_cs = 1'b0;
    idle(4);
    cyc(1'b1, 8'h02, 8'd0, 8'd0);
    idle(1);
    do_reset();
    i_cs = 1'b1;
    idle(6);
    check_val("no_pending_after_rst", 32'(o_slv_tx_enb), 32'd0);
`else
    do_reset();
    cyc(1'b1, 8'h02, 8'd0, 8'd0);
    check_val("nrb_rd_err", 32'(o_err_cnt), 32'd1);
    check_val("nrb_rd_enb", 32'(o_slv_tx_enb), 32'd0);
    idle(3);
    check_val("nrb_enb_stays", 32'(o_slv_tx_enb), 32'd0);
    check_val("nrb_frame", 32'(o_slv_frame), 32'd0);
`endif

    // Random traffic with CS idle; readback frame tracks the latest valid READ.
    i_cs = 1'b1;
    do_reset();
    m_chk_fr = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      int sel;
      logic [7:0] cmd;
      logic [7:0] addr;
      sel  = int'($urandom_range(0, 9));
      cmd  = (sel < 5) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      cyc($urandom_range(0, 11) == 0, cmd, addr, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
